// File: rtl/ftf_decoder_03_pkg.sv
// Shared constants and types for the 3-wire FTF receive path.
// Fibonacci weights, decoded value width, legal-codeword mask, FSM state type.
// Pure declarations; no logic, no latency.
package ftf_decoder_03_pkg;

    // Fibonacci weights for codeword bits b0, b1, b2.
    localparam int FNS01   = 1;
    localparam int FNS02   = 1;
    localparam int FNS03   = 2;

    // Width of a decoded value (0..4).
    localparam int FBLEN03 = 3;

    // Indexed by codeword: bit set means the codeword is a greedy Fibonacci
    // form (000, 010, 100, 110, 111).
    localparam logic [7:0] FTF03_LEGAL = 8'hD5;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } ftf_state_t;

endpackage

// File: rtl/ftf_decoder_03_decode_comb.sv
// Combinational FTF codeword decoder: codeword -> weighted value, legal flag.
// Latency: zero (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   code  : 3-bit FTF codeword
//   value : Fibonacci-weighted value 2*b2 + b1 + b0 (meaningful only when legal)
//   legal : codeword is one of the greedy Fibonacci forms
module ftf_decode_comb_03
    import ftf_decoder_03_pkg::*;
(
    input  logic [2:0]         code,
    output logic [FBLEN03-1:0] value,
    output logic               legal
);

    always_comb begin
        value = FBLEN03'(FNS03 * int'(code[2]) +
                         FNS02 * int'(code[1]) +
                         FNS01 * int'(code[0]));
        legal = FTF03_LEGAL[code];
    end

endmodule

// File: rtl/ftf_decoder_03.sv
// FTF receive stage: two-stage pipeline decoding codewords, flagging illegal
// ones, and gating payload behind an ACQUIRE/LOCKED training FSM.
// Latency: codeword sampled at edge k appears on outputs at edge k+1; no backpressure.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   codein/code_valid : codeword from the bus and its qualifier
//   dataout           : last emitted payload value (holds when data_valid=0)
//   data_valid        : dataout carries a payload this cycle
//   code_err          : sampled codeword was illegal
//   locked            : FSM is in LOCKED
//   err_count         : saturating count of illegal codewords
module ftf_decoder_03
    import ftf_decoder_03_pkg::*;
#(
    parameter int LOCK_THRESH = 8,
    parameter int ERR_THRESH  = 4,
    parameter int ERRW        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         codein,
    input  logic               code_valid,
    output logic [FBLEN03-1:0] dataout,
    output logic               data_valid,
    output logic               code_err,
    output logic               locked,
    output logic [ERRW-1:0]    err_count
);

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(ERR_THRESH + 1);

    // Stage 1: raw capture of the bus.
    logic [2:0]         s1_code;
    logic               s1_vld;

    // Stage 2 state.
    ftf_state_t         state;
    logic [GW-1:0]      good_cnt;
    logic [BW-1:0]      bad_cnt;

    logic [FBLEN03-1:0] dec_value;
    logic               dec_legal;

    ftf_decode_comb_03 u_decode (
        .code  (s1_code),
        .value (dec_value),
        .legal (dec_legal)
    );

    logic emit;
    logic illegal;

    always_comb begin
        // Gate on the state *before* this edge so the lock-completing
        // training codeword is never emitted.
        emit    = s1_vld && dec_legal && (state == LOCKED);
        illegal = s1_vld && !dec_legal;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_code    <= 3'b000;
            s1_vld     <= 1'b0;
            state      <= ACQUIRE;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            s1_code    <= codein;
            s1_vld     <= code_valid;

            data_valid <= emit;
            code_err   <= illegal;
            if (emit) begin
                dataout <= dec_value;
            end

            // Saturate: the flag still pulses, the count just holds.
            if (illegal && (err_count != {ERRW{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end

            // Invalid slots leave the FSM and its counters untouched.
            if (s1_vld) begin
                case (state)
                    ACQUIRE: begin
                        if (dec_legal) begin
                            if (good_cnt == GW'(LOCK_THRESH - 1)) begin
                                state    <= LOCKED;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (dec_legal) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt == BW'(ERR_THRESH - 1)) begin
                            state   <= ACQUIRE;
                            bad_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ACQUIRE;
                    end
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_ftf_decoder_03.sv
module tb_ftf_decoder_03;

    logic       clock;
    logic       reset;
    logic [2:0] codein;
    logic       code_valid;
    logic [2:0] dataout;
    logic       data_valid;
    logic       code_err;
    logic       locked;
    logic [3:0] err_count;

    int checks;
    int failures;

    ftf_decoder_03 #(
        .LOCK_THRESH (8),
        .ERR_THRESH  (4),
        .ERRW        (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .codein     (codein),
        .code_valid (code_valid),
        .dataout    (dataout),
        .data_valid (data_valid),
        .code_err   (code_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one slot at the falling edge, let one rising edge pass, and return
    // at the next falling edge. Outputs then reflect the slot driven one call earlier.
    task automatic step(input logic [2:0] c, input logic v);
        codein     = c;
        code_valid = v;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        reset = 1'b0;
    endtask

    // Train the link with eight legal codewords (no checks here).
    task automatic train8();
        logic [2:0] seq [8];
        seq = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b000, 3'b010, 3'b100};
        for (int i = 0; i < 8; i++) step(seq[i], 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dataout !== 3'd0)    begin failures++; $display("FAIL reset_dataout got=%0d exp=0", dataout); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%0b exp=0", data_valid); end
        checks++; if (code_err !== 1'b0)   begin failures++; $display("FAIL reset_code_err got=%0b exp=0", code_err); end
        checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        checks++; if (err_count !== 4'd0)  begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_lock();
        logic [2:0] seq [8];
        seq = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b000, 3'b010, 3'b100};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(seq[i], 1'b1);
            if (i > 0) begin
                // outputs belong to codeword i-1 (training, never emitted)
                checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL lock_train_dv idx=%0d got=%0b exp=0", i-1, data_valid); end
                checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL lock_early idx=%0d got=%0b exp=0", i-1, locked); end
            end
        end
        step(3'b110, 1'b1);   // outputs of 8th training code
        checks++; if (locked !== 1'b1)     begin failures++; $display("FAIL lock_rise got=%0b exp=1", locked); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL lock_8th_dv got=%0b exp=0", data_valid); end
        step(3'b000, 1'b0);   // outputs of 110
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL lock_first_dv got=%0b exp=1", data_valid); end
        checks++; if (dataout !== 3'd3)    begin failures++; $display("FAIL lock_first_data got=%0d exp=3", dataout); end
    endtask

    task automatic test_stream();
        step(3'b111, 1'b1);   // outputs of bubble
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL stream_bubble0_dv got=%0b exp=0", data_valid); end
        checks++; if (dataout !== 3'd3)    begin failures++; $display("FAIL stream_bubble0_hold got=%0d exp=3", dataout); end
        step(3'b010, 1'b1);   // outputs of 111
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL stream_111_dv got=%0b exp=1", data_valid); end
        checks++; if (dataout !== 3'd4)    begin failures++; $display("FAIL stream_111_data got=%0d exp=4", dataout); end
        step(3'b110, 1'b0);   // outputs of 010; next slot is a bubble with junk code
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL stream_010_dv got=%0b exp=1", data_valid); end
        checks++; if (dataout !== 3'd1)    begin failures++; $display("FAIL stream_010_data got=%0d exp=1", dataout); end
        step(3'b000, 1'b0);   // outputs of bubble
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL stream_bubble1_dv got=%0b exp=0", data_valid); end
        checks++; if (dataout !== 3'd1)    begin failures++; $display("FAIL stream_bubble1_hold got=%0d exp=1", dataout); end
        checks++; if (locked !== 1'b1)     begin failures++; $display("FAIL stream_locked got=%0b exp=1", locked); end
    endtask

    task automatic test_errors();
        logic [2:0] seq  [6];
        logic       eerr [6];
        logic       elck [6];
        seq  = '{3'b001, 3'b110, 3'b011, 3'b101, 3'b101, 3'b001};
        eerr = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1};
        elck = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
        step(seq[0], 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(seq[i+1], 1'b1); else step(3'b000, 1'b0);
            checks++; if (code_err !== eerr[i]) begin failures++; $display("FAIL err_flag idx=%0d got=%0b exp=%0b", i, code_err, eerr[i]); end
            checks++; if (locked !== elck[i])   begin failures++; $display("FAIL err_locked idx=%0d got=%0b exp=%0b", i, locked, elck[i]); end
            if (i == 1) begin
                checks++; if (data_valid !== 1'b1 || dataout !== 3'd3) begin failures++; $display("FAIL err_mid_payload dv=%0b data=%0d exp dv=1 data=3", data_valid, dataout); end
            end
        end
        checks++; if (err_count !== 4'd5) begin failures++; $display("FAIL err_count got=%0d exp=5", err_count); end
    endtask

    task automatic test_relock();
        logic [2:0] seq [16];
        for (int i = 0; i < 16; i++) seq[i] = (i == 7) ? 3'b101 : 3'b010;
        step(seq[0], 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) step(seq[i+1], 1'b1); else step(3'b000, 1'b0);
            checks++; if (locked !== (i == 15)) begin failures++; $display("FAIL relock_locked idx=%0d got=%0b exp=%0b", i, locked, (i == 15)); end
            checks++; if (data_valid !== 1'b0)  begin failures++; $display("FAIL relock_dv idx=%0d got=%0b exp=0", i, data_valid); end
            checks++; if (code_err !== (i == 7)) begin failures++; $display("FAIL relock_err idx=%0d got=%0b exp=%0b", i, code_err, (i == 7)); end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] ill [3];
        int         exp_cnt;
        ill = '{3'b001, 3'b011, 3'b101};
        do_reset();
        step(ill[0], 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) step(ill[(i+1) % 3], 1'b1); else step(3'b000, 1'b0);
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            checks++; if (code_err !== 1'b1) begin failures++; $display("FAIL sat_flag idx=%0d got=%0b exp=1", i, code_err); end
            checks++; if (err_count !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_count idx=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        train8();
        step(3'b111, 1'b1);   // outputs of 8th training code
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_prelock got=%0b exp=1", locked); end
        step(3'b110, 1'b1);   // outputs of 111; 110 now in stage 1
        checks++; if (data_valid !== 1'b1 || dataout !== 3'd4) begin failures++; $display("FAIL mid_payload dv=%0b data=%0d exp dv=1 data=4", data_valid, dataout); end
        reset = 1'b1;
        step(3'b010, 1'b1);
        reset = 1'b0;
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_dv got=%0b exp=0", data_valid); end
        checks++; if (dataout !== 3'd0)    begin failures++; $display("FAIL mid_rst_data got=%0d exp=0", dataout); end
        checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL mid_rst_locked got=%0b exp=0", locked); end
        checks++; if (code_err !== 1'b0 || err_count !== 4'd0) begin failures++; $display("FAIL mid_rst_err err=%0b cnt=%0d exp 0 0", code_err, err_count); end
        step(3'b000, 1'b0);   // stage 1 was flushed: the 010 must not appear
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL mid_post_dv got=%0b exp=0", data_valid); end
        checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL mid_post_locked got=%0b exp=0", locked); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        codein     = 3'b000;
        code_valid = 1'b0;
        @(negedge clock);
        test_reset();
        test_lock();
        test_stream();
        test_errors();
        test_relock();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ftf_decoder_03.md
# ftf_decoder_03

Receive-side stage for the 3-wire FTF link. It sits directly downstream of the 3-bit FTF encoder and the bus. It takes one 3-bit codeword per valid cycle and recovers the Fibonacci-weighted data value. It also flags illegal codewords and runs a lock/acquire state machine, so that a corrupted or untrained link never emits data.

## Interface
Parameters:
- LOCK_THRESH, default 8: consecutive legal codewords needed to enter LOCKED.
- ERR_THRESH, default 4: consecutive illegal codewords in LOCKED that force a return to ACQUIRE.
- ERRW, default 16: width of the error counter.

Ports:
- clock, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high.
- codein, input, 3: FTF codeword from the bus.
- code_valid, input, 1: codein carries a codeword this cycle.
- dataout, output, `FBLEN03: decoded value, 0..4.
- data_valid, output, 1: dataout is a payload value.
- code_err, output, 1: the sampled codeword was illegal.
- locked, output, 1: FSM is in LOCKED.
- err_count, output, ERRW: saturating count of illegal codewords.

## Operation
- Weights are b2 = `FNS03 (2), b1 = `FNS02 (1), b0 = `FNS01 (1). Value = 2·b2 + b1 + b0.
- Legal set is the greedy Fibonacci forms: 000→0, 010→1, 100→2, 110→3, 111→4.
- Illegal set: 001, 011, 101.
- Stage 1 registers codein and code_valid unconditionally each cycle.
- Stage 2 decodes the stage-1 contents, updates the FSM and counters, and registers the outputs.
- FSM states: ACQUIRE (reset state) and LOCKED. The counters below are internal and are evaluated on stage-1 valid codewords only. Cycles where the stage-1 valid is 0 change no counter and no state.
- ACQUIRE, legal codeword: good_cnt increments. When it reaches LOCK_THRESH, the FSM goes to LOCKED and good_cnt clears.
- ACQUIRE, illegal codeword: good_cnt clears.
- LOCKED, legal codeword: bad_cnt clears.
- LOCKED, illegal codeword: bad_cnt increments. When it reaches ERR_THRESH, the FSM goes to ACQUIRE and bad_cnt clears.
- data_valid = stage-1 valid AND legal AND FSM state before this edge == LOCKED. The codeword that completes lock is therefore training and is not emitted.
- dataout updates only when data_valid is 1; otherwise it holds its last value.
- code_err = stage-1 valid AND illegal. It asserts in both states.
- err_count increments on every code_err, in both states, and saturates at 2^ERRW−1.
- locked reflects the registered FSM state.

## Timing
- Reset values: dataout 0, data_valid 0, code_err 0, locked 0, err_count 0, FSM ACQUIRE, both internal counters 0, stage-1 register 0 (invalid).
- Latency: a codeword sampled at rising edge k produces data_valid/dataout/code_err at edge k+1, i.e. two edges after it is presented.
- Throughput: one codeword per cycle with no bubbles. There is no backpressure.
- locked rises on the same edge that outputs the LOCK_THRESH-th legal code's flags (its data_valid = 0). locked falls on the edge that outputs the ERR_THRESH-th illegal flag.
- Reset asserted mid-stream clears both stages on that edge. The codeword in flight is dropped with no output, and lock must be reacquired.
- Simultaneous err_count saturation and code_err: code_err still pulses and the count holds.

## Structure
- Constants go in FNS.vh: FNS01/02/03 and FBLEN03 (existing), plus new `FTF03_LEGAL = 8'hD5. That mask is indexed by codeword and has bits 0, 2, 4, 6, 7 set.
- One combinational sub-module, ftf_decode_comb_03 (codeword → value, legal). It is reusable by wider decoders.
- Pipeline, FSM and counters live in the top module.

## Test plan
- Reset, then 8 valid codewords 000,010,100,110,111,000,010,100 → data_valid never 1; locked rises 2 edges after the 8th codeword. Then 110 → data_valid = 1, dataout = 3.
- In LOCKED, stream 111,010 → dataout 4 then 1 on consecutive cycles. Insert code_valid = 0 bubbles → data_valid = 0 in those slots and dataout holds.
- In LOCKED, send 001, 110, 011, 101, 101, 001 → code_err pulses on each illegal codeword. The 110 clears bad_cnt, so locked drops only on the last 001 (4th consecutive). err_count = 5.
- In ACQUIRE, send 7 legal codewords, then 101, then 7 legal → locked stays 0. The 8th legal after 101 sets locked.
- Preload err_count near saturation (ERRW = 4; send 16 illegal) → err_count stops at 15 while code_err keeps pulsing.
- Assert reset for one cycle while LOCKED with a codeword in stage 1 → no data_valid for it; all outputs 0 on the next cycle; locked = 0.
